otter_io_responder: RTL and testbench
=====================================

// Module: otter_io_responder
// PURPOSE
//  Memory-mapped IO target on the OTTER IOBUS. The CPU is the bus initiator; this block is the responder.
//  Holds LED and seven-segment output registers, synchronises the switches, and runs a prescaled timer.
//  The timer's compare match drives the CPU INTR line. Read data returns on IOBUS_IN one cycle after the
//  address, which matches the synchronous data-memory read timing in the WB stage.
// PARAMETERS
//  BASE_ADDR  32'h1100_0000  base of the 32-byte register window; bits [4:0] must be 0
//  N_SW       16             switch input width (1..32)
//  N_LED      16             LED output width (1..32)
// PORTS
//  CLK         in   1      system clock; all state updates on the rising edge
//  RESET_N     in   1      asynchronous, active-low reset
//  IOBUS_ADDR  in   32     byte address from the CPU MEM stage
//  IOBUS_OUT   in   32     write data from the CPU
//  IOBUS_WR    in   1      write strobe; full 32-bit word write
//  IOBUS_IN    out  32     registered read data to the CPU
//  SWITCHES    in   N_SW   asynchronous board switches
//  LEDS        out  N_LED  LED register
//  SSEG        out  16     seven-segment display value register
//  INTR        out  1      level interrupt request to the CPU
// BEHAVIOUR
//  Decode:
//   - hit = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]); word offset = IOBUS_ADDR[4:2]; IOBUS_ADDR[1:0] ignored.
//  Register map (offset, access):
//   - 0x00 SW RO: sync'd switches, zero-extended.
//   - 0x04 LED RW.
//   - 0x08 SSEG RW: bits [15:0].
//   - 0x0C CTRL RW: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); bits [31:3] read 0.
//   - 0x10 PRESC RW: 32 bits.
//   - 0x14 CMP RW: 32 bits.
//   - 0x18 CNT RW: 32 bits.
//   - 0x1C STAT: bit0 PEND; write 1 to clear (W1C); write 0 has no effect.
//  Writes:
//   - Register updates on the edge where IOBUS_WR && hit.
//   - Write to RO SW, write to any address outside the window, and writes of unused bits are ignored.
//  Reads:
//   - IOBUS_IN <= hit ? reg[offset] : 32'h0, registered every cycle. Latency is 1 cycle; there is no read strobe.
//   - Reads have no side effects.
//   - A read and a write to the same register in the same cycle return the OLD value.
//  Switch sync:
//   - 2-flop synchroniser per bit. A SWITCHES change is visible in an SW read address issued 2 cycles later
//     and appears on IOBUS_IN 3 cycles after the change.
//  Timer, internal 32-bit prescale counter PC:
//   - EN=0: PC and CNT hold.
//   - EN=1: if PC == PRESC, then PC <= 0 and a tick occurs; otherwise PC <= PC+1.
//   - PRESC=0 gives a tick every cycle.
//  Timer, on each tick:
//   - CNT == CMP: set PEND. If AUTO=1, CNT <= 0. If AUTO=0, CNT holds and EN clears (one-shot stop).
//   - Otherwise: CNT <= CNT+1, wrapping 32'hFFFF_FFFF -> 0 with no flag.
//  Timer writes:
//   - A write to CNT or PRESC also clears PC to 0.
//   - A CPU write to CNT, CTRL, or PRESC in the same cycle as a tick takes priority over the tick's update
//     of that register; PEND is still set if the tick matched.
//  PEND:
//   - Set and W1C clear in the same cycle: set wins.
//   - PEND sets regardless of IE.
//  INTR:
//   - INTR = PEND & IE, combinational from registers, level-held until cleared.
//  Reset:
//   - RESET_N low asynchronously clears all registers, PC and the synchronisers: LEDS=0, SSEG=0, IOBUS_IN=0,
//     INTR=0, CTRL=0, PRESC=0, CMP=0, CNT=0, PEND=0.
//   - Reset asserted mid-count aborts the count with no pending interrupt retained.
//   - The first write is accepted on the first rising edge after RESET_N deasserts.
// TESTING
//  1. Reset, then WR 0x1100_0004 <= 0x0000_A5A5 -> LEDS=0xA5A5 next edge; read 0x04 -> IOBUS_IN=0xA5A5 one cycle later.
//  2. SWITCHES=0x1234 held; read 0x1100_0000 -> IOBUS_IN=0x0000_1234. Read 0x1100_0040 (outside window) -> 0x0.
//  3. PRESC=3, CMP=2, CTRL=0x7 -> tick every 4 cycles; PEND and INTR rise at the third tick after enable; CNT reads 0.
//  4. CTRL=0x5 (one-shot), CMP=0, PRESC=0 -> PEND set on first tick; CTRL reads 0x4; CNT stays 0.
//  5. W1C of STAT on the same cycle as a match tick -> PEND remains 1; a later W1C with no tick -> INTR=0 next cycle.
//  6. RESET_N pulsed low mid-count with CNT=5 and PEND=1 -> all outputs 0 immediately, without waiting for CLK.

Source files
------------

// File: rtl/otter_io_responder_if.sv
// otter_io_responder_if: OTTER IOBUS signals between the CPU initiator and an IO responder
interface otter_io_responder_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  modport master (output iobus_addr, iobus_out, iobus_wr, input iobus_in);
  modport slave (input iobus_addr, iobus_out, iobus_wr, output iobus_in);
endinterface

// File: rtl/otter_io_responder.sv
// otter_io_responder: IOBUS target with LED/SSEG registers, synchronised switches and a prescaled compare timer
module otter_io_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int N_SW = 16,
  parameter int N_LED = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  otter_io_responder_if.slave  bus,
  input  logic [N_SW-1:0]      SWITCHES,
  output logic [N_LED-1:0]     LEDS,
  output logic [15:0]          SSEG,
  output logic                 INTR
);
  logic [N_SW-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [15:0] sseg_q, sseg_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [31:0] presc_q, presc_d, cmp_q, cmp_d, cnt_q, cnt_d, pc_q, pc_d, rdata_q, rdata_d;
  logic pend_q, pend_d;
  logic hit, we, tick, match, unused_addr_lsbs;
  logic [2:0] off;
  logic [31:0] wdata;
  assign hit = bus.iobus_addr[31:5] == BASE_ADDR[31:5];
  assign off = bus.iobus_addr[4:2];
  assign unused_addr_lsbs = ^bus.iobus_addr[1:0];
  assign wdata = bus.iobus_out;
  assign we = bus.iobus_wr & hit;
  assign tick = ctrl_q[0] & (pc_q == presc_q);
  assign match = tick & (cnt_q == cmp_q);
  assign LEDS = led_q;
  assign SSEG = sseg_q;
  assign INTR = pend_q & ctrl_q[2];
  assign bus.iobus_in = rdata_q;
  // Next state: CPU writes override the timer's own update of the same register; a match always sets PEND
  always_comb begin
    sw_s1_d = SWITCHES;
    sw_s2_d = sw_s1_q;
    led_d = (we && off == 3'd1) ? wdata[N_LED-1:0] : led_q;
    sseg_d = (we && off == 3'd2) ? wdata[15:0] : sseg_q;
    ctrl_d = (we && off == 3'd3) ? wdata[2:0] : (match && !ctrl_q[1]) ? {ctrl_q[2:1], 1'b0} : ctrl_q;
    presc_d = (we && off == 3'd4) ? wdata : presc_q;
    cmp_d = (we && off == 3'd5) ? wdata : cmp_q;
    cnt_d = (we && off == 3'd6) ? wdata : !tick ? cnt_q : match ? (ctrl_q[1] ? 32'h0 : cnt_q) : cnt_q + 32'h1;
    pc_d = (we && (off == 3'd4 || off == 3'd6)) || tick ? 32'h0 : ctrl_q[0] ? pc_q + 32'h1 : pc_q;
    pend_d = match | (pend_q & ~(we && off == 3'd7 && wdata[0]));
    rdata_d = 32'h0;
    if (hit)
      case (off)
        3'd0: rdata_d = 32'(sw_s2_q);
        3'd1: rdata_d = 32'(led_q);
        3'd2: rdata_d = {16'h0, sseg_q};
        3'd3: rdata_d = {29'h0, ctrl_q};
        3'd4: rdata_d = presc_q;
        3'd5: rdata_d = cmp_q;
        3'd6: rdata_d = cnt_q;
        default: rdata_d = {31'h0, pend_q};
      endcase
  end
  // State registers; reset clears everything including the synchronisers and prescaler
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      led_q <= '0;
      sseg_q <= '0;
      ctrl_q <= '0;
      presc_q <= '0;
      cmp_q <= '0;
      cnt_q <= '0;
      pc_q <= '0;
      pend_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      led_q <= led_d;
      sseg_q <= sseg_d;
      ctrl_q <= ctrl_d;
      presc_q <= presc_d;
      cmp_q <= cmp_d;
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_otter_io_responder.sv
// tb_otter_io_responder: register table plus timer corner-case sequences against otter_io_responder
module tb_otter_io_responder;
  localparam logic [31:0] B = 32'h1100_0000;
  localparam logic [31:0] A_SW = B, A_LED = B + 4, A_SSEG = B + 8, A_CTRL = B + 12;
  localparam logic [31:0] A_PRESC = B + 16, A_CMP = B + 20, A_CNT = B + 24, A_STAT = B + 28;
  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;
  logic CLK = 1'b0, RESET_N = 1'b0;
  logic [15:0] SWITCHES, LEDS, SSEG;
  logic INTR;
  logic [31:0] sb[$];
  int n_cmp = 0, n_bad = 0;
  vec_t tbl[10];
  otter_io_responder_if bus();
  otter_io_responder dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus), .SWITCHES(SWITCHES), .LEDS(LEDS), .SSEG(SSEG), .INTR(INTR));
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.iobus_addr = a;
    bus.iobus_out = d;
    bus.iobus_wr = 1'b1;
    @(negedge CLK);
    bus.iobus_wr = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bus.iobus_addr = a;
    bus.iobus_wr = 1'b0;
    sb.push_back(exp);
    @(posedge CLK);
    #1;
    chk(nm, bus.iobus_in, sb.pop_front());
    @(negedge CLK);
  endtask
  initial begin
    tbl[0] = '{A_LED, 32'hFFFF_A5A5, A_LED, 32'h0000_A5A5};
    tbl[1] = '{A_SSEG, 32'h1234_BEEF, A_SSEG, 32'h0000_BEEF};
    tbl[2] = '{A_CTRL, 32'hFFFF_FFF2, A_CTRL, 32'h0000_0002};
    tbl[3] = '{A_PRESC, 32'hDEAD_BEEF, A_PRESC, 32'hDEAD_BEEF};
    tbl[4] = '{A_CMP, 32'h1234_5678, A_CMP, 32'h1234_5678};
    tbl[5] = '{A_CNT, 32'hCAFE_F00D, A_CNT, 32'hCAFE_F00D};
    tbl[6] = '{A_SW, 32'hFFFF_FFFF, A_SW, 32'h0000_1234};
    tbl[7] = '{B + 32'h24, 32'h0000_FFFF, B + 32'h7, 32'h0000_A5A5};
    tbl[8] = '{32'h1000_0004, 32'h0000_0F0F, B + 32'h5, 32'h0000_A5A5};
    tbl[9] = '{A_STAT, 32'hFFFF_FFFE, A_STAT, 32'h0};
    bus.iobus_addr = '0;
    bus.iobus_out = '0;
    bus.iobus_wr = 1'b0;
    SWITCHES = '0;
    repeat (3) @(negedge CLK);
    chk("rst_iobus_in", bus.iobus_in, 32'h0);
    chk("rst_leds", 32'(LEDS), 32'h0);
    chk("rst_sseg", 32'(SSEG), 32'h0);
    chk("rst_intr", 32'(INTR), 32'h0);
    RESET_N = 1'b1;
    wr(A_LED, 32'h0000_A5A5);
    chk("first_wr_leds", 32'(LEDS), 32'h0000_A5A5);
    rd(A_LED, 32'h0000_A5A5, "rd_led");
    SWITCHES = 16'h1234;
    repeat (3) @(negedge CLK);
    rd(A_SW, 32'h0000_1234, "rd_sw");
    rd(B + 32'h40, 32'h0, "rd_outside");
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      rd(tbl[i].raddr, tbl[i].exp, $sformatf("tbl%0d", i));
    end
    bus.iobus_addr = A_LED;
    bus.iobus_out = 32'h0000_1111;
    bus.iobus_wr = 1'b1;
    sb.push_back(32'h0000_A5A5);
    @(posedge CLK);
    #1;
    chk("rw_same_cycle_old", bus.iobus_in, sb.pop_front());
    @(negedge CLK);
    bus.iobus_wr = 1'b0;
    chk("rw_same_cycle_leds", 32'(LEDS), 32'h0000_1111);
    wr(A_CTRL, 0);
    wr(A_CNT, 0);
    wr(A_CMP, 2);
    wr(A_PRESC, 3);
    wr(A_CTRL, 7);
    repeat (11) @(posedge CLK);
    #1;
    chk("auto_intr_before", 32'(INTR), 32'h0);
    @(posedge CLK);
    #1;
    chk("auto_intr_third_tick", 32'(INTR), 32'h1);
    @(negedge CLK);
    rd(A_CNT, 32'h0, "auto_cnt_reload");
    rd(A_STAT, 32'h1, "auto_pend");
    wr(A_CTRL, 0);
    wr(A_STAT, 1);
    wr(A_CNT, 0);
    wr(A_PRESC, 0);
    wr(A_CMP, 0);
    wr(A_CTRL, 5);
    @(negedge CLK);
    rd(A_CTRL, 32'h4, "oneshot_ctrl");
    chk("oneshot_intr", 32'(INTR), 32'h1);
    rd(A_CNT, 32'h0, "oneshot_cnt");
    wr(A_CTRL, 0);
    wr(A_STAT, 1);
    wr(A_CNT, 0);
    wr(A_CMP, 0);
    wr(A_PRESC, 1);
    wr(A_CTRL, 7);
    repeat (2) @(negedge CLK);
    chk("w1c_pre_intr", 32'(INTR), 32'h1);
    @(negedge CLK);
    wr(A_STAT, 1);
    chk("w1c_vs_tick_set_wins", 32'(INTR), 32'h1);
    wr(A_CTRL, 4);
    chk("w1c_held", 32'(INTR), 32'h1);
    wr(A_STAT, 1);
    chk("w1c_clear", 32'(INTR), 32'h0);
    wr(A_CTRL, 0);
    wr(A_CNT, 0);
    wr(A_CMP, 5);
    wr(A_PRESC, 0);
    wr(A_CTRL, 5);
    repeat (8) @(negedge CLK);
    rd(A_CNT, 32'h5, "pre_rst_cnt");
    chk("pre_rst_intr", 32'(INTR), 32'h1);
    #1 RESET_N = 1'b0;
    #1;
    chk("async_rst_iobus_in", bus.iobus_in, 32'h0);
    chk("async_rst_leds", 32'(LEDS), 32'h0);
    chk("async_rst_sseg", 32'(SSEG), 32'h0);
    chk("async_rst_intr", 32'(INTR), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    rd(A_CNT, 32'h0, "post_rst_cnt");
    rd(A_STAT, 32'h0, "post_rst_pend");
    rd(A_CTRL, 32'h0, "post_rst_ctrl");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
